// File: rtl/booth_mac_accumulator.sv
// booth_mac_accumulator: sums a programmed count of signed 16x16 Booth products into a saturating accumulator
module mul16x16_signed (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  logic signed [31:0] ae, mag;
  logic [16:0] bx;
  logic [2:0] t;
  assign ae = 32'(signed'(a));
  assign bx = {b, 1'b0};
  always_comb begin
    p = '0;
    t = '0;
    mag = '0;
    for (int i = 0; i < 8; i++) begin
      t = bx[2*i +: 3];
      mag = (t == 3'b011 || t == 3'b100) ? ae <<< 1 : (t == 3'b000 || t == 3'b111) ? '0 : ae;
      p = p + 32'((t[2] ? -mag : mag) <<< (2*i));
    end
  end
endmodule

module booth_mac_accumulator #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};
  logic [1:0] state;
  logic [LEN_W-1:0] remaining;
  logic signed [31:0] prod_q;
  logic prod_v, ovf, accept;
  logic signed [ACC_W-1:0] acc, ext, sum;
  logic [31:0] prod;
  mul16x16_signed u_mul (.a(a), .b(b), .p(prod));
  assign ext = ACC_W'(prod_q);
  assign sum = acc + ext;
  // overflow only possible when both addends share a sign and the result flips it
  assign ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  assign in_ready = state == RUN && remaining != '0;
  assign accept = in_valid && in_ready;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign acc_out = acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      remaining <= '0;
      prod_q <= '0;
      prod_v <= 1'b0;
      acc <= '0;
      overflow <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        remaining <= len;
        acc <= '0;
        overflow <= 1'b0;
        prod_v <= 1'b0;
        state <= (len == '0) ? DONE : RUN;
      end
    end else if (state == RUN) begin
      if (accept) begin
        prod_q <= prod;
        remaining <= remaining - LEN_W'(1);
      end
      prod_v <= accept;
      if (prod_v) begin
        acc <= ovf ? (acc[ACC_W-1] ? MINV : MAXV) : sum;
        overflow <= overflow | ovf;
      end
      if (remaining == '0 && !prod_v) state <= DONE;
    end else if (out_ready) begin
      state <= IDLE;
    end
  end
endmodule
